// File: rtl/icache_pkg.sv
// Shared constants and fill-state encoding for the I-cache refill path.
// The cache controller's offset decoding uses the same line geometry.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fill_state_t;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 4;
    localparam int WORD_SEL_W = 2;

endpackage

// File: rtl/icache_line_fill.sv
// Memory-side line-fill responder: fetches a 16-byte line as four in-order
// 32-bit beats, assembles it, and returns it with a one-cycle mem_ready pulse.
module icache_line_fill
    import icache_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ready,
    output logic [127:0]      mem_data,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_valid,
    input  logic [31:0]       ram_rdata
);

    localparam int         LINE_W    = ADDR_W - OFFSET_W;
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

    fill_state_t           state, state_d;
    logic [LINE_W-1:0]     line, line_d;
    logic [WORD_SEL_W-1:0] beat, beat_d, beat_inc;
    logic [3:0]            hold, hold_d;
    logic [95:0]           staging, staging_d;
    logic [127:0]          mem_data_d;
    logic                  mem_ready_d;
    logic                  ram_rd_d;
    logic [ADDR_W-1:0]     ram_addr_d;

    // Byte offset within the line is irrelevant to a whole-line fill.
    logic addr_offset_unused;
    assign addr_offset_unused = ^mem_addr[OFFSET_W-1:0];

    assign beat_inc = beat + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            line      <= '0;
            beat      <= '0;
            hold      <= '0;
            staging   <= '0;
            mem_data  <= '0;
            mem_ready <= 1'b0;
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
        end else begin
            state     <= state_d;
            line      <= line_d;
            beat      <= beat_d;
            hold      <= hold_d;
            staging   <= staging_d;
            mem_data  <= mem_data_d;
            mem_ready <= mem_ready_d;
            ram_rd    <= ram_rd_d;
            ram_addr  <= ram_addr_d;
        end
    end

    always_comb begin
        state_d     = state;
        line_d      = line;
        beat_d      = beat;
        hold_d      = hold;
        staging_d   = staging;
        mem_data_d  = mem_data;
        mem_ready_d = 1'b0;
        ram_rd_d    = ram_rd;
        ram_addr_d  = ram_addr;

        case (state)
            IDLE: begin
                if (mem_r) begin
                    line_d     = mem_addr[ADDR_W-1:OFFSET_W];
                    beat_d     = '0;
                    ram_rd_d   = 1'b1;
                    ram_addr_d = {mem_addr[ADDR_W-1:OFFSET_W], {WORD_SEL_W{1'b0}}, 2'b00};
                    state_d    = FETCH;
                end
            end

            FETCH: begin
                if (ram_rd && ram_valid) begin
                    if (beat == 2'd3) begin
                        // Last beat bypasses staging so the line lands atomically.
                        mem_data_d  = {ram_rdata, staging};
                        mem_ready_d = 1'b1;
                        ram_rd_d    = 1'b0;
                        hold_d      = HOLD_INIT;
                        state_d     = HOLD;
                    end else begin
                        case (beat)
                            2'd0:    staging_d[31:0]  = ram_rdata;
                            2'd1:    staging_d[63:32] = ram_rdata;
                            2'd2:    staging_d[95:64] = ram_rdata;
                            default: staging_d        = staging;
                        endcase
                        beat_d     = beat_inc;
                        ram_addr_d = {line, beat_inc, 2'b00};
                    end
                end
            end

            HOLD: begin
                if (hold == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold - 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill with a transaction-level reference model.
module tb_icache_line_fill;

    localparam int HOLD_CYCLES = 2;
    localparam int ADDR_W      = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mem_r = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic              mem_ready;
    logic [127:0]      mem_data;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_valid = 1'b0;
    logic [31:0]       ram_rdata = '0;

    icache_line_fill #(.HOLD_CYCLES(HOLD_CYCLES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .mem_r(mem_r), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_data(mem_data),
        .ram_rd(ram_rd), .ram_addr(ram_addr),
        .ram_valid(ram_valid), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int addr1238 = 0;
    int stall_cnt = 0;
    int stall_beat = 0;
    bit spur = 1'b0;
    bit cmp_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: a request is a line base address; four accepted words
    // form the line, then the block is deaf for HOLD_CYCLES cycles.
    int          m_phase = 0;          // 0 idle, 1 collecting words, 2 deaf
    int          m_n = 0;
    int          m_cool = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_words [4];
    logic        exp_rd = 1'b0;
    logic        exp_ready = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [127:0] exp_data = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_phase = 0; m_n = 0; m_cool = 0;
            exp_rd = 1'b0; exp_ready = 1'b0; exp_addr = '0; exp_data = '0;
        end else begin
            exp_ready = 1'b0;
            if (m_phase == 0) begin
                if (mem_r) begin
                    m_base   = mem_addr & 32'hFFFF_FFF0;
                    m_n      = 0;
                    exp_rd   = 1'b1;
                    exp_addr = m_base;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                if (ram_valid) begin
                    m_words[m_n] = ram_rdata;
                    m_n++;
                    if (m_n == 4) begin
                        exp_data  = {m_words[3], m_words[2], m_words[1], m_words[0]};
                        exp_ready = 1'b1;
                        exp_rd    = 1'b0;
                        m_cool    = HOLD_CYCLES;
                        m_phase   = 2;
                    end else begin
                        exp_addr = m_base + 32'(4 * m_n);
                    end
                end
            end else begin
                m_cool--;
                if (m_cool == 0) m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ram_rd", 128'(ram_rd), 128'(exp_rd));
            if (exp_rd) check("ram_addr", 128'(ram_addr), 128'(exp_addr));
            check("mem_ready", 128'(mem_ready), 128'(exp_ready));
            check("mem_data", mem_data, exp_data);
        end
        if (mem_ready === 1'b1) pulses++;
    end

    // Instruction RAM: answers addr+0xA000_0000, optionally stalling one beat.
    always @(negedge clk) begin
        if (ram_rd === 1'b1) begin
            if (stall_cnt > 0 && int'(ram_addr[3:2]) == stall_beat) begin
                ram_valid = 1'b0;
                ram_rdata = '0;
                stall_cnt--;
            end else begin
                ram_valid = 1'b1;
                ram_rdata = ram_addr[31:0] + 32'hA000_0000;
            end
            if (ram_addr == 32'h0000_1238) addr1238++;
        end else if (spur) begin
            ram_valid = 1'b1;
            ram_rdata = 32'hDEAD_BEEF;
        end else begin
            ram_valid = 1'b0;
            ram_rdata = '0;
        end
    end

    task automatic wait_ready(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                lat = cyc - t0;
                return;
            end
        end
        check("ready_timeout", 128'(0), 128'(1));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int t0, lat, p0, found;

    initial begin
        rst = 1'b0;
        idle_cycles(3);
        cmp_en = 1'b1;
        check("reset_ram_rd", 128'(ram_rd), 128'(0));
        check("reset_ram_addr", 128'(ram_addr), 128'(0));
        check("reset_mem_ready", 128'(mem_ready), 128'(0));
        check("reset_mem_data", mem_data, 128'(0));
        rst = 1'b1;
        idle_cycles(2);

        // Zero-wait fill
        p0 = pulses;
        mem_r = 1'b1; mem_addr = 32'h0000_1234; t0 = cyc;
        @(negedge clk);
        mem_r = 1'b0;
        wait_ready(t0, lat);
        check("zw_latency", 128'(lat), 128'(5));
        check("zw_data", mem_data, 128'hA000123C_A0001238_A0001234_A0001230);
        idle_cycles(6);
        check("zw_pulses", 128'(pulses - p0), 128'(1));

        // Three wait cycles before beat 2
        p0 = pulses; addr1238 = 0;
        stall_beat = 2; stall_cnt = 3;
        mem_r = 1'b1; mem_addr = 32'h0000_1234; t0 = cyc;
        @(negedge clk);
        mem_r = 1'b0;
        wait_ready(t0, lat);
        check("ws_latency", 128'(lat), 128'(8));
        check("ws_addr_hold", 128'(addr1238), 128'(4));
        check("ws_data", mem_data, 128'hA000123C_A0001238_A0001234_A0001230);
        idle_cycles(6);
        check("ws_pulses", 128'(pulses - p0), 128'(1));

        // Back-to-back with mem_r held high
        mem_r = 1'b1; mem_addr = 32'h0000_0100; t0 = cyc;
        @(negedge clk);
        mem_addr = 32'h0000_0200;
        wait_ready(t0, lat);
        check("b2b_lat1", 128'(lat), 128'(5));
        check("b2b_data1", mem_data, 128'hA000010C_A0000108_A0000104_A0000100);
        found = -1;
        for (int i = 0; i < 20 && found < 0; i++) begin
            @(negedge clk);
            if (ram_rd === 1'b1 && ram_addr == 32'h0000_0200) found = cyc - t0;
        end
        check("b2b_second_start", 128'(found), 128'(8));
        wait_ready(t0, lat);
        mem_r = 1'b0;
        check("b2b_lat2", 128'(lat), 128'(12));
        check("b2b_data2", mem_data, 128'hA000020C_A0000208_A0000204_A0000200);
        idle_cycles(6);

        // Reset during beat 2
        mem_r = 1'b1; mem_addr = 32'h0000_1234;
        @(negedge clk);
        mem_r = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (ram_rd === 1'b1 && ram_addr[3:2] == 2'd2) found = 1;
            else @(negedge clk);
        end
        check("rst_reached_beat2", 128'(found), 128'(1));
        rst = 1'b0;
        @(negedge clk);
        check("rst_ram_rd", 128'(ram_rd), 128'(0));
        check("rst_mem_ready", 128'(mem_ready), 128'(0));
        check("rst_mem_data", mem_data, 128'(0));
        rst = 1'b1; spur = 1'b1;
        idle_cycles(3);
        spur = 1'b0;
        check("rst_late_valid_rd", 128'(ram_rd), 128'(0));
        mem_r = 1'b1; mem_addr = 32'h0000_1234; t0 = cyc;
        @(negedge clk);
        mem_r = 1'b0;
        wait_ready(t0, lat);
        check("rst_refill_lat", 128'(lat), 128'(5));
        check("rst_refill_data", mem_data, 128'hA000123C_A0001238_A0001234_A0001230);
        idle_cycles(6);

        // Address change and request drop mid-fill
        p0 = pulses;
        mem_r = 1'b1; mem_addr = 32'h0000_0500; t0 = cyc;
        @(negedge clk);
        mem_r = 1'b0; mem_addr = 32'h0000_FFF0;
        wait_ready(t0, lat);
        check("drop_lat", 128'(lat), 128'(5));
        check("drop_data", mem_data, 128'hA000050C_A0000508_A0000504_A0000500);
        idle_cycles(10);
        check("drop_pulses", 128'(pulses - p0), 128'(1));
        check("drop_no_refetch", 128'(ram_rd), 128'(0));

        // Spurious ram_valid while idle and through HOLD
        p0 = pulses; spur = 1'b1;
        idle_cycles(4);
        check("spur_idle_data", mem_data, 128'hA000050C_A0000508_A0000504_A0000500);
        mem_r = 1'b1; mem_addr = 32'h0000_0040; t0 = cyc;
        @(negedge clk);
        mem_r = 1'b0;
        wait_ready(t0, lat);
        check("spur_lat", 128'(lat), 128'(5));
        idle_cycles(6);
        spur = 1'b0;
        check("spur_data", mem_data, 128'hA000004C_A0000048_A0000044_A0000040);
        check("spur_pulses", 128'(pulses - p0), 128'(1));
        idle_cycles(3);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Memory-side responder for the instruction cache refill interface (mem_r / mem_addr -> mem_ready / mem_data).
- Accepts a line request from the cache and fetches the 16-byte line as four 32-bit beats from a word-wide instruction memory.
- Assembles the beats into a 128-bit line, then returns it to the cache with a one-cycle mem_ready pulse.
- Sits between the I-cache refill port and the instruction RAM / bus bridge.

Parameters:
- HOLD_CYCLES, 2: cycles after the mem_ready pulse during which mem_r is ignored. Covers the requester's registered view of mem_ready. Legal range 1..15.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets the block).
- mem_r  in  1  line request from the I-cache.
- mem_addr  in  ADDR_W  requested byte address; bits [3:0] ignored.
- mem_ready  out  1  one-cycle pulse: mem_data holds the requested line.
- mem_data  out  128  line data; word k (byte offset 4k) in bits [32k+31:32k].
- ram_rd  out  1  word read request to instruction memory; held until accepted.
- ram_addr  out  ADDR_W  word-aligned read address; bits [1:0] always 0.
- ram_valid  in  1  read data valid; a beat completes when ram_rd & ram_valid.
- ram_rdata  in  32  read data word.

Behaviour:
- Reset: state=IDLE; mem_ready=0; mem_data=0; ram_rd=0; ram_addr=0; beat counter=0; hold counter=0; staging buffer=0.
- Reset mid-fill aborts the fill. Any ram_valid arriving after reset is ignored, because ram_rd is 0.
- States and transitions:
  - IDLE: ram_rd=0. If mem_r==1, latch line=mem_addr[ADDR_W-1:4], set beat=0, go to FETCH.
  - FETCH: ram_rd=1, ram_addr={line, beat[1:0], 2'b00}, all registered.
    - On a cycle with ram_valid==1 and beat<3: write ram_rdata into staging word[beat], increment beat, advance ram_addr by 4 on the next cycle. ram_rd stays 1.
    - On a cycle with ram_valid==1 and beat==3: next cycle mem_data={ram_rdata, staging[95:0]}, mem_ready=1, ram_rd=0, hold=HOLD_CYCLES-1, go to HOLD.
    - ram_valid==0: hold all outputs and counters. Wait states are unbounded; there is no timeout.
  - HOLD: mem_ready=0 after the first cycle. mem_r is ignored. If hold==0 go to IDLE, else decrement hold.
- Latency: mem_r sampled at cycle T; zero-wait RAM gives ram_rd high T+1..T+4 and mem_ready high at T+5. Each RAM wait cycle adds 1.
- mem_data is updated only at line completion (atomic). It stays stable from the mem_ready pulse until the next fill completes, including during the next fill.
- mem_addr changes during FETCH/HOLD are ignored; only the IDLE-cycle address is used.
- mem_r dropping mid-fill does not cancel the fill; the line is still delivered.
- ram_valid while ram_rd==0 (IDLE/HOLD) is ignored.
- Back-to-back requests: mem_r high continuously gives a new fill every 5+HOLD_CYCLES cycles (zero-wait).
- Only one RAM read is outstanding at any time. Beats are issued in order 0,1,2,3; no critical-word-first.
- Beat counter is 2 bits. No wrap beyond beat 3 occurs within a fill because FETCH exits at beat 3.
- Address arithmetic never carries into the line field.

Decomposition:
- Shared package (icache_pkg): fill state encoding (IDLE, FETCH, HOLD), LINE_WORDS=4, OFFSET_W=4, WORD_SEL_W=2.
- These constants are shared with the cache controller's offset decoding.
- Single module. No sub-module is warranted; the staging buffer and counters stay inline.

Test Plan:
- Zero-wait fill: rst released; mem_r=1, mem_addr=0x0000_1234; RAM returns addr+0xA000_0000 each cycle -> ram_addr sequence 0x1230, 0x1234, 0x1238, 0x123C; mem_ready at T+5; mem_data=0xA000_123C_A000_1238_A000_1234_A000_1230.
- Wait states: same request, RAM inserts 3 wait cycles before beat 2 -> ram_addr held at 0x1238 for 4 cycles; mem_ready at T+8; mem_data unchanged during the fill; exactly one mem_ready pulse.
- Back-to-back: mem_r held high with 0x100 then 0x200 (HOLD_CYCLES=2) -> second fill starts at T+7 with ram_addr 0x200; first line stays on mem_data until T+12.
- Reset mid-fill: rst=0 during beat 2 -> next cycle ram_rd=0, mem_ready=0, mem_data=0, state IDLE; a late ram_valid=1 is ignored; a new request after reset completes normally.
- Address change and drop: mem_addr changed to 0xFFF0 and mem_r dropped during FETCH -> fill completes for the original line; no second fill starts.
- Spurious ram_valid: ram_valid=1 while IDLE or in HOLD -> no state change; mem_data unchanged.
